// File: rtl/rice_bus_pkg.sv
// Shared types and master identifiers for the two-master memory bus arbiter.
package rice_bus_pkg;

  typedef logic [0:0] rice_bus_master_id;

  localparam rice_bus_master_id RICE_BUS_MASTER_INST = 1'b0;
  localparam rice_bus_master_id RICE_BUS_MASTER_DATA = 1'b1;

endpackage

// File: rtl/rice_bus_arbiter_tag_fifo.sv
// Small FIFO of master ids for requests the slave has accepted but not yet
// answered. Responses come back in issue order, so the head names the owner.
module rice_bus_arbiter_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  // explicit wrap keeps the pointers correct even when DEPTH is 1
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage is not reset; only pointers and count define validity
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointer and occupancy tracking; push+pop together leaves count alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// Shares one memory bus slave port between instruction fetch (master 0) and
// load/store (master 1): round-robin grant, in-order response routing.
module rice_bus_arbiter
  import rice_bus_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [1:0]                           i_m_request_valid,
  output logic [1:0]                           o_m_request_ready,
  input  logic [2*XLEN-1:0]                    i_m_address,
  input  logic [2*XLEN/8-1:0]                  i_m_strobe,
  input  logic [2*XLEN-1:0]                    i_m_write_data,
  output logic [1:0]                           o_m_response_valid,
  input  logic [1:0]                           i_m_response_ready,
  output logic [XLEN-1:0]                      o_m_read_data,
  output logic                                 o_s_request_valid,
  input  logic                                 i_s_request_ready,
  output logic [XLEN-1:0]                      o_s_address,
  output logic [XLEN/8-1:0]                    o_s_strobe,
  output logic [XLEN-1:0]                      o_s_write_data,
  input  logic                                 i_s_response_valid,
  output logic                                 o_s_response_ready,
  input  logic [XLEN-1:0]                      i_s_read_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding
);

  localparam int SW = XLEN/8;

  rice_bus_master_id grant, prio, lock_id, tag_head;
  logic              lock, tag_full, tag_empty, req_hs, rsp_hs;

  // grant: a stalled request keeps its master; otherwise round-robin on conflict
  always_comb begin
    grant = RICE_BUS_MASTER_INST;
    if (lock)
      grant = lock_id;
    else if (i_m_request_valid[0] && i_m_request_valid[1])
      grant = prio;
    else if (i_m_request_valid[1])
      grant = RICE_BUS_MASTER_DATA;
  end

  assign o_s_request_valid = !i_rst && i_m_request_valid[grant] && !tag_full;
  assign req_hs            = o_s_request_valid && i_s_request_ready;

  // only the granted master ever sees ready
  always_comb begin
    o_m_request_ready        = '0;
    o_m_request_ready[grant] = !i_rst && i_s_request_ready && !tag_full;
  end

  assign o_s_address    = grant[0] ? i_m_address[XLEN +: XLEN]    : i_m_address[0 +: XLEN];
  assign o_s_strobe     = grant[0] ? i_m_strobe[SW +: SW]         : i_m_strobe[0 +: SW];
  assign o_s_write_data = grant[0] ? i_m_write_data[XLEN +: XLEN] : i_m_write_data[0 +: XLEN];

  // lock holds the grant across a stalled request; pointer flips to the loser
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock    <= 1'b0;
      lock_id <= RICE_BUS_MASTER_INST;
      prio    <= RICE_BUS_MASTER_INST;
    end else if (req_hs) begin
      lock <= 1'b0;
      prio <= ~grant;
    end else if (o_s_request_valid) begin
      lock    <= 1'b1;
      lock_id <= grant;
    end
  end

  rice_bus_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (req_hs),
    .pop   (rsp_hs),
    .din   (grant),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (o_outstanding)
  );

  // route the slave response to the master at the head of the tag FIFO
  always_comb begin
    o_m_response_valid = '0;
    o_s_response_ready = 1'b0;
    if (!i_rst && !tag_empty) begin
      o_m_response_valid[tag_head] = i_s_response_valid;
      o_s_response_ready           = i_m_response_ready[tag_head];
    end
  end

  assign rsp_hs        = i_s_response_valid && o_s_response_ready;
  assign o_m_read_data = i_s_read_data;

  // a response with nothing outstanding (including zero-latency) is a slave bug
  a_no_orphan_response: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_s_response_valid && tag_empty));

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Scoreboard bench for rice_bus_arbiter: masters and a fixed-latency slave are
// modelled here; expected grants and responses are queued by hand.
module tb_rice_bus_arbiter;

  localparam int          XLEN = 32;
  localparam logic [31:0] K    = 32'h5A5A_5A5A;
  localparam logic [31:0] WK   = 32'hDEAD_BEEF;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [1:0]        i_m_request_valid, o_m_request_ready;
  logic [2*XLEN-1:0] i_m_address, i_m_write_data;
  logic [7:0]        i_m_strobe;
  logic [1:0]        o_m_response_valid, i_m_response_ready;
  logic [XLEN-1:0]   o_m_read_data;
  logic              o_s_request_valid, i_s_request_ready;
  logic [XLEN-1:0]   o_s_address, o_s_write_data, i_s_read_data;
  logic [3:0]        o_s_strobe;
  logic              i_s_response_valid, o_s_response_ready;
  logic [2:0]        o_outstanding;

  rice_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(4)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_m_request_valid  (i_m_request_valid),
    .o_m_request_ready  (o_m_request_ready),
    .i_m_address        (i_m_address),
    .i_m_strobe         (i_m_strobe),
    .i_m_write_data     (i_m_write_data),
    .o_m_response_valid (o_m_response_valid),
    .i_m_response_ready (i_m_response_ready),
    .o_m_read_data      (o_m_read_data),
    .o_s_request_valid  (o_s_request_valid),
    .i_s_request_ready  (i_s_request_ready),
    .o_s_address        (o_s_address),
    .o_s_strobe         (o_s_strobe),
    .o_s_write_data     (o_s_write_data),
    .i_s_response_valid (i_s_response_valid),
    .o_s_response_ready (o_s_response_ready),
    .i_s_read_data      (i_s_read_data),
    .o_outstanding      (o_outstanding)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct { logic m; logic [31:0] a; } req_t;
  typedef struct { int c; logic [31:0] a; } pend_t;

  req_t  exp_req[$];
  req_t  exp_rsp[$];
  pend_t pend[$];
  req_t  e_mon, r_mon;

  int   n_cmp = 0, n_err = 0, cycnt = 0;
  int   m_left[2] = '{0, 0};
  int   m_seq[2]  = '{0, 0};
  logic rst_c = 1'b1, sready_c = 1'b1, resp_en = 1'b1;
  logic [1:0] rrdy_c = 2'b11;

  function automatic logic [31:0] maddr(input int n, input int s);
    return ((n == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(s * 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT handshake with empty scoreboard", nm);
  endtask

  task automatic expect_req(input logic m, input logic [31:0] a);
    exp_req.push_back('{m, a});
  endtask

  // input driver: masters, slave ready and fixed 2-cycle slave responses
  initial begin
    i_rst = 1'b1; i_m_request_valid = '0; i_m_address = '0; i_m_strobe = '0;
    i_m_write_data = '0; i_m_response_ready = '0; i_s_request_ready = 1'b0;
    i_s_response_valid = 1'b0; i_s_read_data = '0;
    forever begin
      @(posedge i_clk); #1;
      cycnt++;
      i_rst              = rst_c;
      i_s_request_ready  = sready_c;
      i_m_response_ready = rrdy_c;
      for (int n = 0; n < 2; n++) begin
        i_m_request_valid[n]           = (m_left[n] > 0);
        i_m_address[n*XLEN +: XLEN]    = maddr(n, m_seq[n]);
        i_m_write_data[n*XLEN +: XLEN] = maddr(n, m_seq[n]) ^ WK;
        i_m_strobe[n*4 +: 4]           = (n == 1) ? 4'hF : 4'h0;
      end
      if (resp_en && pend.size() > 0 && pend[0].c + 2 <= cycnt) begin
        i_s_response_valid = 1'b1;
        i_s_read_data      = pend[0].a ^ K;
      end else begin
        i_s_response_valid = 1'b0;
        i_s_read_data      = '0;
      end
    end
  end

  // monitor: compares every request and response handshake against the queues
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      if (o_s_request_valid && i_s_request_ready) begin
        pend.push_back('{cycnt, o_s_address});
        if (exp_req.size() == 0) unexp("req_unexpected");
        else begin
          e_mon = exp_req.pop_front();
          chk("req_addr",  o_s_address, e_mon.a);
          chk("req_grant", {30'd0, o_m_request_ready}, e_mon.m ? 32'd2 : 32'd1);
          chk("req_strobe", {28'd0, o_s_strobe}, e_mon.m ? 32'hF : 32'h0);
          chk("req_wdata", o_s_write_data, e_mon.a ^ WK);
          exp_rsp.push_back('{e_mon.m, e_mon.a ^ K});
        end
        for (int n = 0; n < 2; n++)
          if (i_m_request_valid[n] && o_m_request_ready[n]) begin
            m_left[n]--;
            m_seq[n]++;
          end
      end
      for (int n = 0; n < 2; n++)
        if (o_m_response_valid[n] && i_m_response_ready[n]) begin
          if (exp_rsp.size() == 0) unexp("rsp_unexpected");
          else begin
            r_mon = exp_rsp.pop_front();
            chk("rsp_master", n, {31'd0, r_mon.m});
            chk("rsp_data", o_m_read_data, r_mon.a);
          end
        end
      if (i_s_response_valid && o_s_response_ready && pend.size() > 0)
        void'(pend.pop_front());
    end
  end

  // directed sequence
  initial begin
    m_left[0] = 4; m_left[1] = 4;
    for (int i = 0; i < 4; i++) begin
      expect_req(1'b0, maddr(0, i));
      expect_req(1'b1, maddr(1, i));
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_s_req_valid", {31'd0, o_s_request_valid}, 32'd0);
    chk("rst_m_req_ready", {30'd0, o_m_request_ready}, 32'd0);
    chk("rst_m_rsp_valid", {30'd0, o_m_response_valid}, 32'd0);
    chk("rst_s_rsp_ready", {31'd0, o_s_response_ready}, 32'd0);
    chk("rst_outstanding", {29'd0, o_outstanding}, 32'd0);

    // round-robin from master 0, responses 2 cycles after issue
    @(posedge i_clk); rst_c = 1'b0;
    @(negedge i_clk); chk("first_grant_m0", {30'd0, o_m_request_ready}, 32'd1);
    @(negedge i_clk); chk("second_grant_m1", {30'd0, o_m_request_ready}, 32'd2);
    @(negedge i_clk);
    @(negedge i_clk); chk("steady_outstanding", {29'd0, o_outstanding}, 32'd2);
    repeat (8) @(posedge i_clk);
    @(negedge i_clk); chk("drain1_outstanding", {29'd0, o_outstanding}, 32'd0);

    // stalled master 1 keeps the grant although master 0 has priority
    @(posedge i_clk); sready_c = 1'b0; m_left[1] = 1;
    expect_req(1'b1, 32'h2000_0010);
    expect_req(1'b0, 32'h1000_0010);
    @(negedge i_clk);
    chk("lock_s_valid", {31'd0, o_s_request_valid}, 32'd1);
    chk("lock_ready_low", {30'd0, o_m_request_ready}, 32'd0);
    @(posedge i_clk); m_left[0] = 1;
    @(negedge i_clk); chk("lock_addr_c2", o_s_address, 32'h2000_0010);
    @(posedge i_clk);
    @(negedge i_clk); chk("lock_addr_c3", o_s_address, 32'h2000_0010);
    @(posedge i_clk); sready_c = 1'b1;
    @(negedge i_clk); chk("lock_release_m1", {30'd0, o_m_request_ready}, 32'd2);
    @(posedge i_clk);
    @(negedge i_clk); chk("after_lock_m0", {30'd0, o_m_request_ready}, 32'd1);
    repeat (6) @(posedge i_clk);

    // fill the tag FIFO with the slave silent; 5th request must wait
    @(posedge i_clk); resp_en = 1'b0; m_left[0] = 5;
    for (int i = 5; i < 10; i++) expect_req(1'b0, maddr(0, i));
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    chk("full_s_valid", {31'd0, o_s_request_valid}, 32'd0);
    chk("full_m_ready", {30'd0, o_m_request_ready}, 32'd0);
    chk("full_outstanding", {29'd0, o_outstanding}, 32'd4);
    @(posedge i_clk);
    @(negedge i_clk); chk("full_s_valid_2", {31'd0, o_s_request_valid}, 32'd0);
    @(posedge i_clk); resp_en = 1'b1;
    @(negedge i_clk);
    chk("full_pop_cycle_s_valid", {31'd0, o_s_request_valid}, 32'd0);
    chk("full_pop_s_rsp_ready", {31'd0, o_s_response_ready}, 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("fifth_issued", {31'd0, o_s_request_valid}, 32'd1);
    chk("fifth_addr", o_s_address, 32'h1000_0024);
    chk("fifth_outstanding", {29'd0, o_outstanding}, 32'd3);
    @(posedge i_clk);
    @(negedge i_clk); chk("push_pop_count3", {29'd0, o_outstanding}, 32'd3);
    repeat (6) @(posedge i_clk);

    // master 0 response held off; master 1 response queued behind it
    @(posedge i_clk); m_left[0] = 1; rrdy_c = 2'b10;
    expect_req(1'b0, 32'h1000_0028);
    expect_req(1'b1, 32'h2000_0014);
    @(posedge i_clk); m_left[1] = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("hold_rsp_valid", {30'd0, o_m_response_valid}, 32'd1);
    chk("hold_s_rsp_ready", {31'd0, o_s_response_ready}, 32'd0);
    chk("hold_data", o_m_read_data, 32'h4A5A_5A72);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("hold_rsp_valid_2", {30'd0, o_m_response_valid}, 32'd1);
    chk("hold_s_rsp_ready_2", {31'd0, o_s_response_ready}, 32'd0);
    chk("hold_data_2", o_m_read_data, 32'h4A5A_5A72);
    chk("hold_outstanding", {29'd0, o_outstanding}, 32'd2);
    @(posedge i_clk); rrdy_c = 2'b11;
    @(negedge i_clk); chk("release_s_rsp_ready", {31'd0, o_s_response_ready}, 32'd1);
    repeat (5) @(posedge i_clk);

    @(negedge i_clk);
    chk("end_outstanding", {29'd0, o_outstanding}, 32'd0);
    chk("end_req_left", exp_req.size(), 32'd0);
    chk("end_rsp_left", exp_rsp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
